// File: rtl/qspi_register_bridge_pkg.sv
// Shared opcodes, FSM state encodings and the device-ID byte selector for the QSPI register bridge.
package qspi_register_bridge_pkg;

  typedef enum logic [7:0] {
    OP_WRITE   = 8'h01,
    OP_READ    = 8'h02,
    OP_READ_ID = 8'haa
  } opcode_t;

  typedef logic [2:0] bridge_state_t;

  localparam bridge_state_t ST_IDLE       = 3'd0;
  localparam bridge_state_t ST_ADDR       = 3'd1;
  localparam bridge_state_t ST_WRITE_DATA = 3'd2;
  localparam bridge_state_t ST_READ_DATA  = 3'd3;
  localparam bridge_state_t ST_READ_WAIT  = 3'd4;
  localparam bridge_state_t ST_READ_ID    = 3'd5;
  localparam bridge_state_t ST_DISCARD    = 3'd6;

  // cnt 0 selects the most significant byte, so the ID streams out MSB first.
  function automatic logic [7:0] id_byte(input logic [31:0] word, input logic [1:0] cnt);
    logic [7:0] b;
    case (cnt)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/qspi_register_bridge_if.sv
// Bridge signal bundle: QSPI core byte stream on one side, byte-wide register bus on the other.
interface qspi_register_bridge_if #(
  parameter int ADDR_BITS = 16
);
  logic                 start;
  logic                 insn_valid;
  logic [7:0]           insn;
  logic                 wr_valid;
  logic [7:0]           wr_data;
  logic                 rd_mode;
  logic                 rd_ready;
  logic                 rd_valid;
  logic [7:0]           rd_data;
  logic [ADDR_BITS-1:0] bus_addr;
  logic                 bus_wr_en;
  logic [7:0]           bus_wr_data;
  logic                 bus_rd_en;
  logic                 bus_rd_valid;
  logic [7:0]           bus_rd_data;
  logic                 err_timeout;

  modport master (
    output start, insn_valid, insn, wr_valid, wr_data, rd_ready, bus_rd_valid, bus_rd_data,
    input  rd_mode, rd_valid, rd_data, bus_addr, bus_wr_en, bus_wr_data, bus_rd_en, err_timeout
  );

  modport slave (
    input  start, insn_valid, insn, wr_valid, wr_data, rd_ready, bus_rd_valid, bus_rd_data,
    output rd_mode, rd_valid, rd_data, bus_addr, bus_wr_en, bus_wr_data, bus_rd_en, err_timeout
  );
endinterface

// File: rtl/qspi_register_bridge.sv
// Decodes QSPI insn/addr/data bytes into register bus strobes and returns read/ID bytes to the core.
// All outputs registered: strobes 1 cycle after the input pulse, rd_ready -> rd_valid >= 3 cycles for bus reads.
module qspi_register_bridge
  import qspi_register_bridge_pkg::*;
#(
  parameter int          ADDR_BITS    = 16,
  parameter logic [31:0] ID_WORD      = 32'hfeedface,
  parameter int          TIMEOUT      = 255,
  parameter logic [7:0]  TIMEOUT_DATA = 8'hff
) (
  input  logic                  clk,
  input  logic                  rst,
  qspi_register_bridge_if.slave bif
);

  localparam int NBYTES = ADDR_BITS / 8;
  localparam int BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  bridge_state_t        state;
  bridge_state_t        cur_state;
  logic [ADDR_BITS-1:0] addr;
  logic [BC_W-1:0]      byte_cnt;
  logic                 is_read;
  logic [1:0]           id_cnt;
  logic                 discard;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 tmo_hit;

  logic                 rd_mode_q;
  logic                 rd_valid_q;
  logic [7:0]           rd_data_q;
  logic                 bus_wr_en_q;
  logic [7:0]           bus_wr_data_q;
  logic                 bus_rd_en_q;
  logic                 err_timeout_q;

  // start wins over the registered state so a same-cycle opcode decodes from IDLE.
  assign cur_state = bif.start ? ST_IDLE : state;
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      addr          <= '0;
      byte_cnt      <= '0;
      is_read       <= 1'b0;
      id_cnt        <= 2'd0;
      discard       <= 1'b0;
      tmo_cnt       <= '0;
      rd_mode_q     <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= 8'h00;
      bus_wr_en_q   <= 1'b0;
      bus_wr_data_q <= 8'h00;
      bus_rd_en_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state         <= cur_state;
      rd_valid_q    <= 1'b0;
      bus_wr_en_q   <= 1'b0;
      bus_rd_en_q   <= 1'b0;
      err_timeout_q <= 1'b0;

      if (bus_wr_en_q) addr <= addr + ADDR_BITS'(1);

      if (bif.start) begin
        rd_mode_q <= 1'b0;
        byte_cnt  <= '0;
        id_cnt    <= 2'd0;
        if (state == ST_READ_WAIT && !bif.bus_rd_valid) discard <= 1'b1;
      end

      // An abandoned bus read is drained by its late response or by the timeout, whichever comes first.
      if (discard && state != ST_READ_WAIT) begin
        if (bif.bus_rd_valid || tmo_hit) discard <= 1'b0;
        else                             tmo_cnt <= tmo_cnt + TMO_W'(1);
      end

      case (cur_state)
        ST_IDLE: begin
          if (bif.insn_valid) begin
            if (bif.insn == OP_WRITE || bif.insn == OP_READ) begin
              state    <= ST_ADDR;
              is_read  <= (bif.insn == OP_READ);
              byte_cnt <= '0;
            end else if (bif.insn == OP_READ_ID) begin
              state     <= ST_READ_ID;
              rd_mode_q <= 1'b1;
            end else begin
              state <= ST_DISCARD;
            end
          end
          if (bif.rd_ready) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= 8'h00;
          end
        end

        ST_ADDR: begin
          if (bif.wr_valid) begin
            addr <= (addr << 8) | ADDR_BITS'(bif.wr_data);
            if (byte_cnt == BC_W'(NBYTES - 1)) begin
              state     <= is_read ? ST_READ_DATA : ST_WRITE_DATA;
              rd_mode_q <= is_read;
            end else begin
              byte_cnt <= byte_cnt + BC_W'(1);
            end
          end
          if (bif.rd_ready) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= 8'h00;
          end
        end

        ST_WRITE_DATA: begin
          if (bif.wr_valid) begin
            bus_wr_en_q   <= 1'b1;
            bus_wr_data_q <= bif.wr_data;
          end
          if (bif.rd_ready) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= 8'h00;
          end
        end

        ST_READ_DATA: begin
          if (bif.rd_ready) begin
            bus_rd_en_q <= 1'b1;
            state       <= ST_READ_WAIT;
            tmo_cnt     <= '0;
          end
        end

        ST_READ_WAIT: begin
          if (bif.bus_rd_valid) begin
            if (discard) begin
              discard <= 1'b0;
            end else begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= bif.bus_rd_data;
              addr       <= addr + ADDR_BITS'(1);
              state      <= ST_READ_DATA;
            end
          end else if (tmo_hit) begin
            rd_valid_q    <= 1'b1;
            rd_data_q     <= TIMEOUT_DATA;
            err_timeout_q <= 1'b1;
            addr          <= addr + ADDR_BITS'(1);
            state         <= ST_READ_DATA;
            discard       <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        ST_READ_ID: begin
          if (bif.rd_ready) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= id_byte(ID_WORD, id_cnt);
            id_cnt     <= id_cnt + 2'd1;
          end
        end

        default: begin
          if (bif.rd_ready) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= 8'h00;
          end
        end
      endcase
    end
  end

  assign bif.rd_mode     = rd_mode_q;
  assign bif.rd_valid    = rd_valid_q;
  assign bif.rd_data     = rd_data_q;
  assign bif.bus_addr    = addr;
  assign bif.bus_wr_en   = bus_wr_en_q;
  assign bif.bus_wr_data = bus_wr_data_q;
  assign bif.bus_rd_en   = bus_rd_en_q;
  assign bif.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_qspi_register_bridge.sv
// Directed bench for qspi_register_bridge: write, read, ID, timeout, abort and unknown-opcode sequences.
module tb_qspi_register_bridge;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  qspi_register_bridge_if #(.ADDR_BITS(16)) bif ();

  qspi_register_bridge #(.ADDR_BITS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_start();
    bif.start = 1'b1;
    step();
    bif.start = 1'b0;
  endtask

  task automatic send_insn(input logic [7:0] op, input logic with_start);
    bif.insn       = op;
    bif.insn_valid = 1'b1;
    bif.start      = with_start;
    step();
    bif.insn_valid = 1'b0;
    bif.start      = 1'b0;
  endtask

  task automatic send_wr(input logic [7:0] d);
    bif.wr_data  = d;
    bif.wr_valid = 1'b1;
    step();
    bif.wr_valid = 1'b0;
  endtask

  task automatic req_rd();
    bif.rd_ready = 1'b1;
    step();
    bif.rd_ready = 1'b0;
  endtask

  task automatic bus_reply(input logic [7:0] d);
    bif.bus_rd_data  = d;
    bif.bus_rd_valid = 1'b1;
    step();
    bif.bus_rd_valid = 1'b0;
  endtask

  function automatic logic [47:0] all_outs();
    return 48'({bif.rd_mode, bif.rd_valid, bif.rd_data, bif.bus_addr, bif.bus_wr_en,
                bif.bus_wr_data, bif.bus_rd_en, bif.err_timeout});
  endfunction

  logic [7:0] wdat [3];
  logic [7:0] rdat [2];
  logic [7:0] idat [6];
  int         n;

  initial begin
    checks   = 0;
    failures = 0;
    wdat = '{8'h11, 8'h22, 8'h33};
    rdat = '{8'ha5, 8'h5a};
    idat = '{8'hfe, 8'hed, 8'hfa, 8'hce, 8'hfe, 8'hed};

    rst              = 1'b1;
    bif.start        = 1'b0;
    bif.insn_valid   = 1'b0;
    bif.insn         = 8'h00;
    bif.wr_valid     = 1'b0;
    bif.wr_data      = 8'h00;
    bif.rd_ready     = 1'b0;
    bif.bus_rd_valid = 1'b0;
    bif.bus_rd_data  = 8'h00;
    repeat (3) step();
    chk("reset_outputs", all_outs(), 48'h0);
    rst = 1'b0;
    step();
    chk("idle_outputs", all_outs(), 48'h0);

    // Write burst of three bytes starting at 0x0010
    send_start();
    send_insn(8'h01, 1'b0);
    send_wr(8'h00);
    send_wr(8'h10);
    chk("wr_rd_mode_after_addr", 48'(bif.rd_mode), 48'h0);
    for (int i = 0; i < 3; i++) begin
      send_wr(wdat[i]);
      chk($sformatf("wr_strobe%0d", i), 48'({bif.bus_wr_en, bif.bus_addr, bif.bus_wr_data}),
          48'({1'b1, 16'h0010 + 16'(i), wdat[i]}));
    end
    step();
    chk("wr_strobe_end", 48'({bif.bus_wr_en, bif.rd_mode}), 48'h0);

    // Register read of two bytes from 0x0020
    send_start();
    send_insn(8'h02, 1'b0);
    send_wr(8'h00);
    chk("rd_mode_mid_addr", 48'(bif.rd_mode), 48'h0);
    send_wr(8'h20);
    chk("rd_mode_after_addr", 48'(bif.rd_mode), 48'h1);
    for (int i = 0; i < 2; i++) begin
      req_rd();
      chk($sformatf("rd_bus_req%0d", i), 48'({bif.bus_rd_en, bif.bus_addr}),
          48'({1'b1, 16'h0020 + 16'(i)}));
      step();
      chk($sformatf("rd_wait%0d", i), 48'({bif.bus_rd_en, bif.rd_valid}), 48'h0);
      bus_reply(rdat[i]);
      chk($sformatf("rd_return%0d", i), 48'({bif.rd_valid, bif.rd_data}), 48'({1'b1, rdat[i]}));
    end

    // Device ID, opcode issued in the same cycle as start
    send_insn(8'haa, 1'b1);
    chk("id_rd_mode", 48'(bif.rd_mode), 48'h1);
    for (int i = 0; i < 6; i++) begin
      req_rd();
      chk($sformatf("id_byte%0d", i), 48'({bif.rd_valid, bif.rd_data}), 48'({1'b1, idat[i]}));
    end

    // Silent responder at 0xFFFF: timeout, then the address wraps to 0x0000
    send_start();
    send_insn(8'h02, 1'b0);
    send_wr(8'hff);
    send_wr(8'hff);
    req_rd();
    chk("tmo_bus_req", 48'({bif.bus_rd_en, bif.bus_addr}), 48'({1'b1, 16'hffff}));
    n = 0;
    while (!bif.rd_valid && n < 400) begin
      step();
      n++;
    end
    chk("tmo_cycles", 48'(n), 48'd255);
    chk("tmo_return", 48'({bif.rd_valid, bif.err_timeout, bif.rd_data}), 48'({2'b11, 8'hff}));
    step();
    chk("tmo_pulse_end", 48'({bif.rd_valid, bif.err_timeout}), 48'h0);
    req_rd();
    chk("wrap_bus_req", 48'({bif.bus_rd_en, bif.bus_addr}), 48'({1'b1, 16'h0000}));
    step();
    bus_reply(8'h3c);
    chk("wrap_return", 48'({bif.rd_valid, bif.rd_data}), 48'({1'b1, 8'h3c}));

    // Abort an outstanding read; the late response must vanish
    send_start();
    send_insn(8'h02, 1'b0);
    send_wr(8'h00);
    send_wr(8'h40);
    req_rd();
    chk("abort_bus_req", 48'({bif.bus_rd_en, bif.bus_addr}), 48'({1'b1, 16'h0040}));
    step();
    send_start();
    chk("abort_rd_mode", 48'(bif.rd_mode), 48'h0);
    bus_reply(8'h77);
    chk("abort_late_drop", 48'(bif.rd_valid), 48'h0);
    step();
    chk("abort_late_drop2", 48'(bif.rd_valid), 48'h0);
    send_insn(8'haa, 1'b0);
    req_rd();
    chk("abort_id_first", 48'({bif.rd_valid, bif.rd_data}), 48'({1'b1, 8'hfe}));

    // Unknown opcode: no bus activity, rd_ready answered with 00
    send_start();
    send_insn(8'h7f, 1'b0);
    send_wr(8'h12);
    chk("discard_no_write", 48'({bif.bus_wr_en, bif.bus_rd_en}), 48'h0);
    req_rd();
    chk("discard_rd_answer", 48'({bif.rd_valid, bif.rd_data, bif.bus_rd_en, bif.bus_wr_en}),
        48'({1'b1, 8'h00, 2'b00}));

    // Reset in the middle of a write burst
    send_start();
    send_insn(8'h01, 1'b0);
    send_wr(8'h00);
    send_wr(8'h50);
    send_wr(8'h99);
    chk("rst_pre_strobe", 48'({bif.bus_wr_en, bif.bus_addr, bif.bus_wr_data}),
        48'({1'b1, 16'h0050, 8'h99}));
    rst = 1'b1;
    step();
    chk("rst_mid_write", all_outs(), 48'h0);
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
